// File: rtl/mips_lw_top.sv
// Single-cycle MIPS-subset execute/memory/write-back datapath.
// 32x32 register file, 256-word data memory, externally supplied instruction.
module mips_lw_top (
    input  logic [31:0] instru,
    input  logic        clk,
    input  logic        rst,
    input  logic        read,
    output logic [31:0] result,
    input  logic        init,
    output logic [31:0] addr_out,
    input  logic        write
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    logic [31:0] rf_q  [32];
    logic [31:0] mem_q [256];
    logic [31:0] result_q, result_d;
    logic [31:0] addr_q, addr_d;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] simm, rs_v, rt_v, ea, alu, wb, mem_rd;
    logic [4:0]  wr_idx;
    logic        rf_we, mem_we, rf_wr, mem_wr;
    logic        unused_shamt;

    assign op    = instru[31:26];
    assign rs    = instru[25:21];
    assign rt    = instru[20:16];
    assign rd    = instru[15:11];
    assign funct = instru[5:0];
    assign simm  = {{16{instru[15]}}, instru[15:0]};

    assign unused_shamt = ^instru[10:6];

    assign rs_v   = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_v   = (rt == 5'd0) ? 32'd0 : rf_q[rt];
    assign ea     = rs_v + simm;
    assign mem_rd = mem_q[ea[9:2]];

    always_comb begin
        alu    = 32'd0;
        addr_d = 32'd0;
        wb     = 32'd0;
        wr_idx = rt;
        rf_we  = 1'b0;
        mem_we = 1'b0;
        unique case (op)
            OP_LW: begin
                addr_d = ea;
                wb     = mem_rd;
                rf_we  = 1'b1;
            end
            OP_SW: begin
                addr_d = ea;
                wb     = rt_v;
                mem_we = 1'b1;
            end
            OP_ADDI: begin
                addr_d = ea;
                wb     = ea;
                rf_we  = 1'b1;
            end
            OP_RTYPE: begin
                wr_idx = rd;
                rf_we  = 1'b1;
                unique case (funct)
                    FN_ADD:  alu = rs_v + rt_v;
                    FN_SUB:  alu = rs_v - rt_v;
                    FN_AND:  alu = rs_v & rt_v;
                    FN_OR:   alu = rs_v | rt_v;
                    FN_SLT:  alu = {31'd0, $signed(rs_v) < $signed(rt_v)};
                    default: rf_we = 1'b0;
                endcase
                addr_d = alu;
                wb     = alu;
            end
            default: ;
        endcase
    end

    // Readback uses pre-edge register contents, independent of the write.
    assign result_d = read ? rt_v : wb;
    assign rf_wr    = rf_we && write && (wr_idx != 5'd0);
    assign mem_wr   = mem_we && write;

    always_ff @(posedge clk) begin
        if (!rst) begin
            result_q <= 32'd0;
            addr_q   <= 32'd0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (init) begin
            result_q <= 32'd0;
            addr_q   <= 32'd0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'(i);
        end else begin
            result_q <= result_d;
            addr_q   <= addr_d;
            if (rf_wr) rf_q[wr_idx] <= wb;
        end
    end

    // Memory survives reset; only init or a gated store changes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (init) begin
                for (int i = 0; i < 256; i++) mem_q[i] <= 32'(i);
            end else if (mem_wr) begin
                mem_q[ea[9:2]] <= rt_v;
            end
        end
    end

    assign result   = result_q;
    assign addr_out = addr_q;

endmodule

// File: tb/tb_mips_lw_top.sv
// Randomised self-checking bench for mips_lw_top.
// Directed plan cases first, then random mixed traffic vs. a reference model.
module tb_mips_lw_top;

    logic [31:0] instru;
    logic        clk, rst, read, init, write;
    logic [31:0] result, addr_out;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_rf  [32];
    logic [31:0] m_mem [256];
    logic [31:0] exp_res, exp_addr;

    mips_lw_top dut (
        .instru   (instru),
        .clk      (clk),
        .rst      (rst),
        .read     (read),
        .result   (result),
        .init     (init),
        .addr_out (addr_out),
        .write    (write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int op, input int s,
                                          input int t, input int imm);
        return {6'(op), 5'(s), 5'(t), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(input int s, input int t,
                                          input int d, input int fn);
        return {6'd0, 5'(s), 5'(t), 5'(d), 5'd0, 6'(fn)};
    endfunction

    // Reference: behaviour written straight from the instruction semantics.
    task automatic model(input logic [31:0] ins, input logic rs_n,
                         input logic in, input logic w, input logic r);
        int op, fn, s, t, d, dest;
        logic [31:0] a, b, imm, v, ad;
        bit wr_rf, wr_mem;
        op = int'(ins[31:26]);
        s  = int'(ins[25:21]);
        t  = int'(ins[20:16]);
        d  = int'(ins[15:11]);
        fn = int'(ins[5:0]);
        if (!rs_n) begin
            exp_res = 0; exp_addr = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = 0;
            return;
        end
        if (in) begin
            exp_res = 0; exp_addr = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = i;
            for (int i = 0; i < 256; i++) m_mem[i] = i;
            return;
        end
        a = m_rf[s];
        b = m_rf[t];
        imm = 32'(signed'(ins[15:0]));
        v = 0; ad = 0; wr_rf = 0; wr_mem = 0; dest = t;
        if (op == 35) begin
            ad = a + imm; v = m_mem[(ad / 4) % 256]; wr_rf = 1;
        end else if (op == 43) begin
            ad = a + imm; v = b; wr_mem = 1;
        end else if (op == 8) begin
            ad = a + imm; v = ad; wr_rf = 1;
        end else if (op == 0) begin
            dest = d;
            wr_rf = 1;
            if (fn == 32) v = a + b;
            else if (fn == 34) v = a - b;
            else if (fn == 36) v = a & b;
            else if (fn == 37) v = a | b;
            else if (fn == 42) v = ($signed(a) < $signed(b)) ? 1 : 0;
            else wr_rf = 0;
            ad = v;
        end
        exp_res  = r ? b : v;
        exp_addr = ad;
        if (w && wr_rf && dest != 0) m_rf[dest] = v;
        if (w && wr_mem) m_mem[(ad / 4) % 256] = b;
    endtask

    task automatic step(input logic [31:0] ins, input logic rs_n,
                        input logic in, input logic w, input logic r);
        instru = ins; rst = rs_n; init = in; write = w; read = r;
        model(ins, rs_n, in, w, r);
        @(posedge clk);
        #1;
        check("result", result, exp_res);
        check("addr_out", addr_out, exp_addr);
    endtask

    function automatic logic [31:0] rand_ins();
        int k;
        int fns[5] = '{32, 34, 36, 37, 42};
        k = $urandom_range(0, 9);
        case (k)
            0, 1: return enc_i(35, $urandom % 32, $urandom % 32, $urandom);
            2:    return enc_i(43, $urandom % 32, $urandom % 32, $urandom);
            3:    return enc_i(8, $urandom % 32, $urandom % 32, $urandom);
            4, 5, 6, 7:
                return enc_r($urandom % 32, $urandom % 32, $urandom % 32,
                             fns[$urandom % 5]);
            8:    return {6'h3F, 26'($urandom)};
            default:
                return enc_r($urandom % 32, $urandom % 32, $urandom % 32, 1);
        endcase
    endfunction

    logic [31:0] rd8;

    initial begin
        instru = 0; rst = 0; init = 0; write = 0; read = 0;
        rd8 = {6'h3F, 5'd0, 5'd8, 16'd0};

        step($urandom, 0, 0, 1, 0);
        step($urandom, 0, 0, 1, 0);
        check("rst_result", result, 32'd0);
        check("rst_addr", addr_out, 32'd0);
        step(rd8, 1, 0, 1, 1);
        check("rst_r8", result, 32'd0);

        step($urandom, 1, 1, 1, 0);
        step(32'h8D084555, 1, 0, 1, 0);
        check("lw1_addr", addr_out, 32'h0000455D);
        check("lw1_res", result, 32'h57);
        step(32'h8D084555, 1, 0, 1, 0);
        check("lw2_addr", addr_out, 32'h000045AC);
        check("lw2_res", result, 32'h6B);
        step(32'h8D08455F, 1, 0, 1, 0);
        check("lw3_addr", addr_out, 32'h000045CA);
        check("lw3_res", result, 32'h72);

        step(0, 1, 1, 1, 0);
        step(32'h8D084555, 1, 0, 0, 0);
        check("nowr_res", result, 32'h57);
        step(rd8, 1, 0, 1, 1);
        check("nowr_r8", result, 32'd8);

        step(0, 1, 1, 1, 0);
        step(enc_i(43, 5, 3, 0), 1, 0, 1, 0);
        step(enc_i(35, 5, 9, 0), 1, 0, 1, 0);
        check("sw_lw", result, 32'd3);
        step(enc_r(2, 3, 10, 34), 1, 0, 1, 0);
        check("sub", result, 32'hFFFFFFFF);
        step(enc_r(10, 1, 11, 42), 1, 0, 1, 0);
        check("slt", result, 32'd1);

        step({6'h3F, 26'h3FFFFFF}, 1, 0, 1, 0);
        check("nop_res", result, 32'd0);
        check("nop_addr", addr_out, 32'd0);
        step(enc_i(8, 1, 0, 5), 1, 0, 1, 0);
        step({6'h3F, 5'd0, 5'd0, 16'd0}, 1, 0, 1, 1);
        check("r0", result, 32'd0);

        for (int n = 0; n < 600; n++) begin
            logic rn, in, w, r;
            rn = ($urandom % 60) != 0;
            in = ($urandom % 50) == 0;
            w  = ($urandom % 8) != 0;
            r  = ($urandom % 4) == 0;
            step(rand_ins(), rn, in, w, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
